// File: rtl/mpu_data_types.sv
// Shared MPU data types: scalar float encoding and result-collector FSM states.
package mpu_data_types;

  typedef logic [31:0] float_sp;

  typedef enum logic [0:0] {
    COLLECTOR_IDLE  = 1'b0,
    COLLECTOR_WRITE = 1'b1
  } collector_state_e;

endpackage

// File: rtl/mpu_collector_ptr.sv
// Row-major (di,dj) destination pointer for the result collector write-out.
module mpu_collector_ptr #(
  parameter int unsigned M  = 3,
  parameter int unsigned N  = 3,
  parameter int unsigned CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  output logic [CW-1:0] di,
  output logic [CW-1:0] dj,
  output logic [CW-1:0] next_di,
  output logic [CW-1:0] next_dj,
  output logic          last
);

  logic row_end;
  logic col_end;

  assign col_end = (dj == CW'(N - 1));
  assign row_end = (di == CW'(M - 1));
  assign last    = row_end & col_end;

  always_comb begin
    next_dj = col_end ? '0 : dj + CW'(1);
    next_di = di;
    if (col_end) begin
      next_di = row_end ? '0 : di + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      di <= '0;
      dj <= '0;
    end else if (clear) begin
      di <= '0;
      dj <= '0;
    end else if (advance) begin
      di <= next_di;
      dj <= next_dj;
    end
  end

endmodule

// File: rtl/mpu_result_collector.sv
// Collects M*N out-of-order results into a buffer, then streams them (optionally
// transposed) to the register file one element per accepted cycle.
module mpu_result_collector
  import mpu_data_types::*;
#(
  parameter int unsigned M = 3,
  parameter int unsigned N = 3,
  localparam int unsigned MaxMn = (M > N) ? M : N,
  localparam int unsigned CW = (MaxMn > 1) ? $clog2(MaxMn) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [M*N*32-1:0] result_in,
  input  logic [M*N-1:0]    ready_in,
  input  logic              transpose_in,
  input  logic              error_detected_in,
  input  logic              reg_ready_in,
  output logic              collector_active_write_out,
  output logic [CW-1:0]     reg_collector_i_out,
  output logic [CW-1:0]     reg_collector_j_out,
  output float_sp           reg_collector_element_out,
  output logic              collector_finished,
  output logic              collector_error_out
);

  localparam int unsigned NumEl = M * N;
  localparam logic TrOk = 1'(M == N);

  collector_state_e state_q, state_d;
  logic [NumEl-1:0] valid_q, valid_d;
  float_sp          buf_q [NumEl];
  float_sp          buf_d [NumEl];
  logic             tr_q, tr_d;
  logic             active_q, active_d;
  logic [CW-1:0]    i_q, i_d, j_q, j_d;
  float_sp          elem_q, elem_d;
  logic             fin_q, fin_d;
  logic             err_q, err_d;

  logic [CW-1:0] di, dj, next_di, next_dj;
  logic          last;
  logic          ptr_clear, ptr_adv;
  logic          accept, final_acc;

  // Transposed read swaps row/column; only reachable when M == N.
  function automatic float_sp pick(input float_sp mem [NumEl], input int unsigned r,
                                   input int unsigned c, input logic tr);
    int unsigned idx;
    float_sp     v;
    idx = tr ? (c * N + r) : (r * N + c);
    v   = '0;
    for (int unsigned k = 0; k < NumEl; k++) begin
      if (k == idx) v = mem[k];
    end
    return v;
  endfunction

  mpu_collector_ptr #(
    .M (M),
    .N (N),
    .CW(CW)
  ) u_ptr (
    .clk    (clk),
    .rst    (rst),
    .clear  (ptr_clear),
    .advance(ptr_adv),
    .di     (di),
    .dj     (dj),
    .next_di(next_di),
    .next_dj(next_dj),
    .last   (last)
  );

  assign accept    = active_q & reg_ready_in;
  assign final_acc = (state_q == COLLECTOR_WRITE) & accept & last;

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    buf_d     = buf_q;
    tr_d      = tr_q;
    active_d  = active_q;
    i_d       = i_q;
    j_d       = j_q;
    elem_d    = elem_q;
    fin_d     = 1'b0;
    err_d     = 1'b0;
    ptr_clear = 1'b0;
    ptr_adv   = 1'b0;

    if (error_detected_in) begin
      state_d   = COLLECTOR_IDLE;
      valid_d   = '0;
      active_d  = 1'b0;
      i_d       = '0;
      j_d       = '0;
      elem_d    = '0;
      err_d     = 1'b1;
      ptr_clear = 1'b1;
    end else begin
      if (final_acc) valid_d = '0;
      // Strobes on the final-acceptance edge start the next matrix.
      if (state_q == COLLECTOR_IDLE || final_acc) begin
        for (int unsigned k = 0; k < NumEl; k++) begin
          if (ready_in[k]) begin
            buf_d[k]   = result_in[k*32 +: 32];
            valid_d[k] = 1'b1;
          end
        end
      end

      unique case (state_q)
        COLLECTOR_IDLE: begin
          if (&valid_q) begin
            state_d   = COLLECTOR_WRITE;
            tr_d      = transpose_in & TrOk;
            active_d  = 1'b1;
            i_d       = '0;
            j_d       = '0;
            elem_d    = buf_d[0];
            ptr_clear = 1'b1;
          end
        end
        COLLECTOR_WRITE: begin
          if (final_acc) begin
            state_d   = COLLECTOR_IDLE;
            active_d  = 1'b0;
            i_d       = '0;
            j_d       = '0;
            elem_d    = '0;
            fin_d     = 1'b1;
            ptr_clear = 1'b1;
          end else begin
            if (|ready_in) err_d = 1'b1;
            if (accept) begin
              ptr_adv = 1'b1;
              i_d     = next_di;
              j_d     = next_dj;
              elem_d  = pick(buf_q, 32'(next_di), 32'(next_dj), tr_q);
            end
          end
        end
        default: state_d = COLLECTOR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= COLLECTOR_IDLE;
      valid_q  <= '0;
      for (int unsigned k = 0; k < NumEl; k++) buf_q[k] <= '0;
      tr_q     <= 1'b0;
      active_q <= 1'b0;
      i_q      <= '0;
      j_q      <= '0;
      elem_q   <= '0;
      fin_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      buf_q    <= buf_d;
      tr_q     <= tr_d;
      active_q <= active_d;
      i_q      <= i_d;
      j_q      <= j_d;
      elem_q   <= elem_d;
      fin_q    <= fin_d;
      err_q    <= err_d;
    end
  end

  assign collector_active_write_out = active_q;
  assign reg_collector_i_out        = i_q;
  assign reg_collector_j_out        = j_q;
  assign reg_collector_element_out  = elem_q;
  assign collector_finished         = fin_q;
  assign collector_error_out        = err_q;

endmodule

// File: doc/mpu_result_collector.md
MPU_RESULT_COLLECTOR -- requirements
Module: mpu_result_collector

Interface
REQ-001 Parameter: M, default 3, result rows (1..8).
REQ-002 Parameter: N, default 3, result columns (1..8).
REQ-003 Derived constant: CW = max(1, $clog2(max(M,N))), width of every index output.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  clock, all state on rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 result_in  in  M*N*32  float_sp results; element (i,j) at slice index i*N+j.
REQ-008 ready_in  in  M*N  per-element result strobe; bit i*N+j qualifies element (i,j).
REQ-009 transpose_in  in  1  write-out mode select, sampled on the IDLE->WRITE transition edge.
REQ-010 error_detected_in  in  1  abort request.
REQ-011 reg_ready_in  in  1  register file accepts the current element.
REQ-012 collector_active_write_out  out  1  element/index outputs valid.
REQ-013 reg_collector_i_out, reg_collector_j_out  out  CW each  destination row/column.
REQ-014 reg_collector_element_out  out  32  float_sp element.
REQ-015 collector_finished  out  1  one-cycle pulse after last element accepted.
REQ-016 collector_error_out  out  1  one-cycle pulse on abort or overrun.

Function
REQ-017 States COLLECTOR_IDLE and COLLECTOR_WRITE; all outputs registered.
REQ-018 IDLE: each set ready_in bit captures its result into buffer and sets that element's valid bit; completion order is arbitrary.
REQ-019 IDLE: repeated strobe for an already-valid element overwrites it; latest value wins.
REQ-020 All M*N valid bits set after edge E -> at edge E+1 state = WRITE, transpose_in latched, active = 1, first element loaded.
REQ-021 Traversal row-major over destination (di,dj); element out = buffer[di][dj] normally, buffer[dj][di] when latched transpose = 1.
REQ-022 Transpose = 1 legal only when M == N; otherwise treated as 0.
REQ-023 Handshake: while active = 1 and reg_ready_in = 0, index and element outputs hold stable.
REQ-024 Edge with active = 1 and reg_ready_in = 1 accepts current element; next element loaded same edge (one element per cycle at full throughput).
REQ-025 Acceptance of (M-1,N-1): state -> IDLE, active -> 0, element/index outputs -> 0, all valid bits cleared, collector_finished = 1 for exactly the following cycle.
REQ-026 ready_in bit set during WRITE: result discarded, collector_error_out pulses, write-out continues unaffected.
REQ-027 error_detected_in = 1 in any state: next edge state -> IDLE, valid bits cleared, active -> 0, outputs -> 0, collector_error_out pulses; no collector_finished.
REQ-028 error_detected_in and final acceptance on the same edge: error wins, no finished pulse.
REQ-029 ready_in on the final-acceptance edge is captured as a fresh element of the next matrix.
REQ-030 M = N = 1: single element, write-out lasts one accepted cycle.

Reset
REQ-031 rst asserted: state = IDLE, valid bits 0, buffer 0, pointers 0, all outputs 0, immediately and without a clock edge.
REQ-032 rst mid-write: write-out abandoned, no finished or error pulse generated.

Structure
REQ-033 collector_state_e (COLLECTOR_IDLE, COLLECTOR_WRITE) and float_sp stay in the shared mpu_data_types package; no new package types.
REQ-034 One sub-module, mpu_collector_ptr: row-major (di,dj) counter with advance/clear inputs and last-element flag.
REQ-035 Buffer and valid bits held in the top module; no memory macro inference required.

Verification
REQ-036 M=N=3, strobes in reverse order (8..0) one per cycle, reg_ready_in=1 -> active rises one cycle after strobe 0, nine elements (0,0)..(2,2) on consecutive cycles, finished pulses once.
REQ-037 M=N=3, transpose_in=1, result(i,j)=10*i+j -> element at destination (0,1) equals 10.0-pattern value of (1,0).
REQ-038 reg_ready_in toggling 1,0,0,1,... -> no element skipped or duplicated, outputs stable during stalls, exactly nine acceptances.
REQ-039 error_detected_in asserted while at element (1,2) -> active 0 next cycle, error pulses, no finished; next full matrix collected correctly.
REQ-040 ready_in bit 4 strobed during WRITE -> error pulses, written value unchanged; M=2,N=4 run completes in 8 accepts with i in 0..1, j in 0..3.
